// File: rtl/dcache_wb_if.sv
// Bus bundle for dcache_wb: pipeline request/response signals and the
// line-granular main-memory port.
interface dcache_wb_if;
    logic         req_rd;
    logic         req_wr;
    logic         req_byte;
    logic [31:0]  addr;
    logic [31:0]  wdata;
    logic [31:0]  rdata;
    logic         dhit;
    logic         mem_req;
    logic         mem_we;
    logic [31:0]  mem_addr;
    logic [127:0] mem_wdata;
    logic [127:0] mem_rdata;
    logic         mem_ack;

    modport master (
        output req_rd, req_wr, req_byte, addr, wdata, mem_rdata, mem_ack,
        input  rdata, dhit, mem_req, mem_we, mem_addr, mem_wdata
    );

    modport slave (
        input  req_rd, req_wr, req_byte, addr, wdata, mem_rdata, mem_ack,
        output rdata, dhit, mem_req, mem_we, mem_addr, mem_wdata
    );
endinterface

// File: rtl/dcache_wb.sv
// Direct-mapped, write-back, write-allocate data cache with 16-byte lines.
// dhit stalls the pipeline while a writeback/refill is in flight.
module dcache_wb #(
    parameter int unsigned LINES = 4,
    parameter int unsigned TAG_W = 32 - 4 - $clog2(LINES)
) (
    input  logic       clk,
    input  logic       reset,
    dcache_wb_if.slave bus
);
    localparam int unsigned IDX_W = $clog2(LINES);

    typedef enum logic [1:0] {IDLE, WRITEBACK, REFILL} state_e;

    state_e             state_q, state_d;
    logic [LINES-1:0]   valid_q, valid_d;
    logic [LINES-1:0]   dirty_q, dirty_d;
    logic [TAG_W-1:0]   tag_q  [LINES];
    logic [TAG_W-1:0]   tag_d  [LINES];
    logic [127:0]       data_q [LINES];
    logic [127:0]       data_d [LINES];
    logic               mem_req_q, mem_req_d;
    logic               mem_we_q, mem_we_d;
    logic [31:0]        mem_addr_q, mem_addr_d;
    logic [127:0]       mem_wdata_q, mem_wdata_d;

    logic               request;
    logic               hit;
    logic               idle_hit;
    logic [IDX_W-1:0]   idx;
    logic [TAG_W-1:0]   tag_in;
    logic [1:0]         word;

    assign idx    = bus.addr[4 +: IDX_W];
    assign tag_in = bus.addr[31 -: TAG_W];
    assign word   = bus.addr[3:2];

    // Word 0 sits in the top bits of the line, so ~word selects the slice.
    always_comb begin
        request  = bus.req_rd | bus.req_wr;
        hit      = valid_q[idx] && (tag_q[idx] == tag_in);
        idle_hit = (state_q == IDLE) && hit;
    end

    assign bus.dhit      = ~request | idle_hit;
    assign bus.rdata     = idle_hit ? data_q[idx][{~word, 5'b0} +: 32] : '0;
    assign bus.mem_req   = mem_req_q;
    assign bus.mem_we    = mem_we_q;
    assign bus.mem_addr  = mem_addr_q;
    assign bus.mem_wdata = mem_wdata_q;

    always_comb begin
        state_d     = state_q;
        valid_d     = valid_q;
        dirty_d     = dirty_q;
        tag_d       = tag_q;
        data_d      = data_q;
        mem_req_d   = mem_req_q;
        mem_we_d    = mem_we_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;

        case (state_q)
            IDLE: begin
                if (request && hit) begin
                    if (bus.req_wr) begin
                        // Byte lanes are big-endian: addr[3:0]==0 is line bits [127:120].
                        if (bus.req_byte)
                            data_d[idx][{~bus.addr[3:0], 3'b0} +: 8] = bus.wdata[7:0];
                        else
                            data_d[idx][{~word, 5'b0} +: 32] = bus.wdata;
                        dirty_d[idx] = 1'b1;
                    end
                end else if (request) begin
                    mem_req_d = 1'b1;
                    if (valid_q[idx] && dirty_q[idx]) begin
                        state_d     = WRITEBACK;
                        mem_we_d    = 1'b1;
                        mem_addr_d  = {tag_q[idx], idx, 4'b0};
                        mem_wdata_d = data_q[idx];
                    end else begin
                        state_d    = REFILL;
                        mem_we_d   = 1'b0;
                        mem_addr_d = {bus.addr[31:4], 4'b0};
                    end
                end
            end
            WRITEBACK: begin
                if (bus.mem_ack) begin
                    state_d    = REFILL;
                    mem_we_d   = 1'b0;
                    mem_addr_d = {bus.addr[31:4], 4'b0};
                end
            end
            REFILL: begin
                if (bus.mem_ack) begin
                    state_d      = IDLE;
                    mem_req_d    = 1'b0;
                    mem_we_d     = 1'b0;
                    data_d[idx]  = bus.mem_rdata;
                    tag_d[idx]   = tag_in;
                    valid_d[idx] = 1'b1;
                    dirty_d[idx] = 1'b0;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            valid_q     <= '0;
            dirty_q     <= '0;
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
        end else begin
            state_q     <= state_d;
            valid_q     <= valid_d;
            dirty_q     <= dirty_d;
            mem_req_q   <= mem_req_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
        end
    end

    // Tag and data arrays carry no reset; valid bits gate their use.
    always_ff @(posedge clk) begin
        tag_q  <= tag_d;
        data_q <= data_d;
    end
endmodule

// File: tb/tb_dcache_wb.sv
// Scoreboard bench for dcache_wb: a flat program-view memory model predicts
// load data, hit/miss and writeback contents while a responder emulates memory.
module tb_dcache_wb;
    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    dcache_wb_if bus ();
    dcache_wb #(.LINES(4)) dut (.clk(clk), .reset(reset), .bus(bus));

    typedef struct {
        logic [31:0] rdata;
        bit          hit;
        logic [31:0] a;
    } exp_t;

    int unsigned n_cmp = 0;
    int unsigned n_fail = 0;
    exp_t        exp_q[$];
    exp_t        mon_e;
    logic [127:0] mem_m  [int unsigned];
    logic [31:0]  view_m [int unsigned];
    int          res_line [4];
    bit          res_dirty[4];
    bit          first_cycle = 0;
    bit          done = 0;
    bit          mem_en = 1;
    int unsigned lat_fixed = 0;
    int unsigned wait_cnt = 0;
    int unsigned exp_wb = 0;
    int unsigned act_wb = 0;
    int unsigned exp_refill_la = 0;
    logic [31:0] last_rdata = '0;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [127:0] init_line(int unsigned la);
        logic [127:0] l;
        if (la == 4) return 128'h11111111_22222222_33333333_44444444;
        for (int k = 0; k < 4; k++)
            l[127-32*k -: 32] = {16'hC0DE ^ la[15:0], 8'(la), 8'(k)};
        return l;
    endfunction

    function automatic logic [127:0] mem_line(int unsigned la);
        return mem_m.exists(la) ? mem_m[la] : init_line(la);
    endfunction

    function automatic logic [31:0] view_rd(int unsigned wa);
        logic [127:0] l;
        if (view_m.exists(wa)) return view_m[wa];
        l = mem_line(wa >> 4);
        return l[127-32*((wa >> 2) & 3) -: 32];
    endfunction

    function automatic logic [127:0] view_line(int unsigned la);
        logic [127:0] l;
        for (int k = 0; k < 4; k++) l[127-32*k -: 32] = view_rd(la * 16 + k * 4);
        return l;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 4; i++) begin
            res_line[i]  = -1;
            res_dirty[i] = 0;
        end
        view_m.delete();
    endtask

    task automatic do_req(input bit rd, input bit wr, input bit byt,
                          input logic [31:0] a, input logic [31:0] d);
        int unsigned la;
        int unsigned idx;
        int unsigned wa;
        int unsigned lane;
        logic [31:0] w;
        exp_t e;
        int cnt;
        la  = a >> 4;
        idx = la % 4;
        wa  = a & 32'hFFFF_FFFC;
        e.hit   = (res_line[idx] == int'(la));
        e.rdata = view_rd(wa);
        e.a     = a;
        exp_q.push_back(e);
        if (!e.hit) begin
            if (res_line[idx] >= 0 && res_dirty[idx]) exp_wb++;
            res_line[idx]  = int'(la);
            res_dirty[idx] = 0;
            exp_refill_la  = la;
        end
        if (wr) begin
            if (byt) begin
                w = view_rd(wa);
                lane = a & 3;
                w[31-8*lane -: 8] = d[7:0];
                view_m[wa] = w;
            end else begin
                view_m[wa] = d;
            end
            res_dirty[idx] = 1;
        end
        bus.req_rd   = rd;
        bus.req_wr   = wr;
        bus.req_byte = byt;
        bus.addr     = a;
        bus.wdata    = d;
        done         = 0;
        first_cycle  = 1;
        cnt = 0;
        while (!done && cnt < 80) begin
            @(posedge clk);
            cnt++;
        end
        if (!done) begin
            n_cmp++;
            n_fail++;
            $display("FAIL timeout addr %h: dhit never rose within 80 cycles", a);
            exp_q.delete();
            first_cycle = 0;
        end
        #1;
        bus.req_rd   = 0;
        bus.req_wr   = 0;
        bus.req_byte = 0;
    endtask

    // Monitor: checks first-cycle hit prediction and the data presented when dhit rises.
    initial begin
        forever begin
            @(negedge clk);
            if (!reset && (bus.req_rd || bus.req_wr) && exp_q.size() > 0 && !done) begin
                if (first_cycle) begin
                    check("dhit_first", bus.dhit, exp_q[0].hit);
                    first_cycle = 0;
                end
                if (bus.dhit) begin
                    mon_e = exp_q.pop_front();
                    check("rdata", bus.rdata, mon_e.rdata);
                    last_rdata = bus.rdata;
                    done = 1;
                end
            end
        end
    end

    // Memory responder with random or fixed latency.
    initial begin
        bus.mem_ack   = 0;
        bus.mem_rdata = '0;
        forever begin
            @(posedge clk);
            #1;
            if (mem_en) begin
                bus.mem_ack = 0;
                if (bus.mem_req) begin
                    if (wait_cnt == 0) wait_cnt = (lat_fixed != 0) ? lat_fixed : $urandom_range(1, 4);
                    wait_cnt--;
                    if (wait_cnt == 0) begin
                        if (bus.mem_we) begin
                            act_wb++;
                            check("wb_data", bus.mem_wdata, view_line(bus.mem_addr >> 4));
                            check("wb_addr_align", {124'd0, bus.mem_addr[3:0]}, 128'd0);
                            mem_m[bus.mem_addr >> 4] = bus.mem_wdata;
                        end else begin
                            check("refill_addr", bus.mem_addr, {exp_refill_la[27:0], 4'b0});
                            bus.mem_rdata = mem_line(bus.mem_addr >> 4);
                        end
                        bus.mem_ack = 1;
                    end
                end
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int cnt;
        logic [31:0] a;
        int unsigned kind;
        bus.req_rd   = 0;
        bus.req_wr   = 0;
        bus.req_byte = 0;
        bus.addr     = '0;
        bus.wdata    = '0;
        reset        = 1;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        reset = 0;

        check("rst_dhit", bus.dhit, 1);
        check("rst_mem_req", bus.mem_req, 0);
        check("rst_mem_we", bus.mem_we, 0);
        check("rst_mem_addr", bus.mem_addr, 0);
        check("rst_mem_wdata", bus.mem_wdata, 0);
        check("rst_rdata", bus.rdata, 0);

        lat_fixed = 3;
        do_req(1, 0, 0, 32'h40, 32'h0);
        check("tp_read40", last_rdata, 32'h11111111);
        do_req(1, 0, 0, 32'h48, 32'h0);
        check("tp_read48", last_rdata, 32'h33333333);
        do_req(0, 1, 1, 32'h41, 32'hFFFFFFAB);
        do_req(1, 0, 0, 32'h40, 32'h0);
        check("tp_byte_store", last_rdata, 32'h11AB1111);
        do_req(1, 0, 0, 32'h80, 32'h0);
        check("tp_conflict_wb", act_wb, 1);
        lat_fixed = 0;

        // Reset while a refill is outstanding.
        mem_en = 0;
        bus.mem_ack = 0;
        bus.addr = 32'hC0;
        bus.req_rd = 1;
        cnt = 0;
        while (!(bus.mem_req && !bus.mem_we) && cnt < 10) begin
            @(posedge clk);
            #1;
            cnt++;
        end
        check("rst_refill_seen", bus.mem_req && !bus.mem_we, 1);
        reset = 1;
        bus.req_rd = 0;
        @(posedge clk);
        #1;
        reset = 0;
        check("midrst_mem_req", bus.mem_req, 0);
        check("midrst_dhit", bus.dhit, 1);
        bus.mem_rdata = {4{32'hDEADBEEF}};
        bus.mem_ack = 1;
        @(posedge clk);
        #1;
        bus.mem_ack = 0;
        repeat (2) begin
            check("late_ack_mem_req", bus.mem_req, 0);
            @(posedge clk);
            #1;
        end
        model_reset();
        wait_cnt = 0;
        mem_en = 1;
        do_req(1, 0, 0, 32'hC0, 32'h0);
        do_req(1, 0, 0, 32'h40, 32'h0);

        // Idle cycles with stray acks.
        mem_en = 0;
        for (int i = 0; i < 10; i++) begin
            bus.mem_ack = 1'($urandom_range(0, 1));
            @(posedge clk);
            #1;
            check("idle_dhit", bus.dhit, 1);
            check("idle_mem_req", bus.mem_req, 0);
        end
        bus.mem_ack = 0;
        wait_cnt = 0;
        mem_en = 1;

        for (int i = 0; i < 300; i++) begin
            a = 32'($urandom_range(0, 255));
            kind = $urandom_range(0, 3);
            if (kind < 2) do_req(1, 0, 0, a, $urandom);
            else do_req(1'($urandom_range(0, 1)), 1, kind == 3, a, $urandom);
            if ($urandom_range(0, 3) == 0) begin
                @(posedge clk);
                #1;
            end
        end

        check("wb_count", act_wb, exp_wb);
        check("queue_empty", exp_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
